cla_seq_addsub: RTL and testbench
=================================

Name: cla_seq_addsub

Overview:
Multi-cycle 16-bit add/subtract unit built on a single shared CLA_4bit slice, processing one nibble per clock from LSB to MSB.
- Reuses the slice instead of a 16-bit adder: area over latency.
- Sits beside the ALU and serves non-critical arithmetic, such as address/offset calculation and the PADDSB-style saturating path.
- Uses a valid/ready handshake on the input side and on the result side.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4; NSLICE = WIDTH/4 nibble steps.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  requester presents an operation
start_ready  output  1  unit can accept an operation (high only in IDLE)
a  input  WIDTH  operand A, two's complement
b  input  WIDTH  operand B, two's complement
sub  input  1  0 = A+B, 1 = A-B
res_valid  output  1  result registers hold a completed operation
res_ready  input  1  consumer accepts the result
sum  output  WIDTH  result (saturated or wrapped; see Optional Feature)
cout  output  1  carry out of MSB nibble (for subtract: 1 = no borrow)
ovfl  output  1  signed overflow of the unsaturated result
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: any edge with rst=1 forces state IDLE, sum=0, cout=0, ovfl=0, res_valid=0, nibble index=0, carry register=0. rst overrides start_valid/res_ready on the same edge. After reset, start_ready=1 and busy=0.
- States:
  - IDLE: start_ready=1. On an edge with start_valid=1:
    - latch a into opA;
    - latch b XOR {WIDTH{sub}} into opB;
    - set carry = sub, idx = 0;
    - go to RUN.
    Otherwise stay in IDLE.
  - RUN: slice inputs are opA[4*idx+:4], opB[4*idx+:4], carry. Each edge:
    - sum_int[4*idx+:4] <= slice S;
    - carry <= slice cout;
    - idx <= idx+1.
    At idx == NSLICE-1, go to DONE and register cout, ovfl and the final sum on that same edge. start_valid is ignored throughout RUN.
  - DONE: res_valid=1. sum, cout and ovfl are held stable while res_ready=0. On an edge with res_ready=1, go to IDLE (res_valid=0, start_ready=1 the next cycle). No overlap: a new op cannot be accepted on the result-handshake edge.
- Latency: res_valid rises exactly NSLICE clocks after the accepting edge (4 for WIDTH=16). Minimum throughput is one op per NSLICE+2 clocks.
- Overflow: ovfl = (opA[MSB] == opB[MSB]) && (raw_sum[MSB] != opA[MSB]), where opB is the inverted B for subtract. cout is the raw final slice carry and is independent of saturation.
- Width rule: all arithmetic is modulo 2^WIDTH; there are no hidden extra bits.
- Mid-operation reset: rst in RUN or DONE aborts the op and returns all outputs to reset values. The partial result is never presented.
- sum_int is internal; the sum output changes only on the RUN->DONE edge or on reset.

Optional Feature:
Macro: CLA_SEQ_SATURATE_EN.
- Defined: when ovfl=1, sum = 0x7FFF (WIDTH-generic: 0 followed by ones) if opA[MSB]=0, else 0x8000 (1 followed by zeros). ovfl and cout still report the raw result.
- Undefined: sum is always the wrapped raw result. No saturation mux is synthesized, and ovfl is still computed.

Test Plan:
1. a=0x1234, b=0x0FED, sub=0 -> sum=0x2221, cout=0, ovfl=0; res_valid rises 4 clocks after the accept edge; start_ready=0 and busy=1 throughout.
2. a=0x0FFF, b=0x0001, sub=0 (carry ripples across 3 nibble steps) -> sum=0x1000, cout=0, ovfl=0. Then a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovfl=0.
3. a=0x7FFF, b=0x0001, sub=0 -> ovfl=1, cout=0; sum=0x7FFF with CLA_SEQ_SATURATE_EN, 0x8000 without. Also a=0x8000, b=0x0001, sub=1 -> ovfl=1, cout=1; sum=0x8000 with the macro, 0x7FFF without.
4. Back-pressure: complete op 1 and hold res_ready=0 for 3 clocks while start_valid=1 with new operands -> sum, cout and ovfl stable, start_ready=0, new op not latched. Raise res_ready -> IDLE next clock, then the new op is accepted.
5. Reset mid-op: accept a=0xAAAA, b=0x5555, assert rst on the 2nd RUN clock -> next clock state IDLE, res_valid=0, sum=0, busy=0, start_ready=1. A following op a=0x0001, b=0x0001 -> sum=0x0002.
6. Reset priority: rst=1 and start_valid=1 on the same edge -> nothing accepted; start_ready=1 and busy=0 after the edge.

Source files
------------

// File: rtl/cla_seq_addsub.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit CLA slice, one nibble per clock.
// Optional saturation of the result on signed overflow: define CLA_SEQ_SATURATE_EN.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module cla_seq_addsub #(
  parameter int WIDTH = 16  // must be a multiple of 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_int;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic             last;
  logic             ovfl_raw;

  cla_4bit u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  // raw_sum merges the nibble being produced this cycle so the final edge sees the full result
  always_comb begin
    nib_a                = op_a[4*idx +: 4];
    nib_b                = op_b[4*idx +: 4];
    raw_sum              = sum_int;
    raw_sum[4*idx +: 4]  = nib_s;
    last                 = (idx == IW'(NSLICE - 1));
    ovfl_raw             = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (raw_sum[WIDTH-1] != op_a[WIDTH-1]);
`ifdef CLA_SEQ_SATURATE_EN
    sum_next = ovfl_raw ? {op_a[WIDTH-1], {(WIDTH-1){~op_a[WIDTH-1]}}} : raw_sum;
`else
    sum_next = raw_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      sum_int <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovfl    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_int[4*idx +: 4] <= nib_s;
          carry               <= nib_c;
          if (last) begin
            idx  <= '0;
            sum  <= sum_next;
            cout <= nib_c;
            ovfl <= ovfl_raw;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_addsub.sv
// Self-checking bench for cla_seq_addsub: directed cases with literal results plus random traffic
// compared every cycle against a transaction-level arithmetic model.
`timescale 1ns/1ps
module tb_cla_seq_addsub;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

`ifdef CLA_SEQ_SATURATE_EN
  localparam logic [WIDTH-1:0] POS_OVF = 16'h7FFF;
  localparam logic [WIDTH-1:0] NEG_OVF = 16'h8000;
`else
  localparam logic [WIDTH-1:0] POS_OVF = 16'h8000;
  localparam logic [WIDTH-1:0] NEG_OVF = 16'h7FFF;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  always #5 clk = ~clk;

  cla_seq_addsub #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovfl        (ovfl),
    .busy        (busy)
  );

  task automatic chkw(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on true integer values
  task automatic ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit s,
                        output logic [WIDTH-1:0] r, output bit c, output bit v);
    longint sx, sy, full, hi, lo;
    sx = longint'(x);
    sy = longint'(y);
    if (x[WIDTH-1]) sx -= (longint'(1) << WIDTH);
    if (y[WIDTH-1]) sy -= (longint'(1) << WIDTH);
    full = s ? (sx - sy) : (sx + sy);
    hi   = (longint'(1) << (WIDTH - 1)) - 1;
    lo   = -(longint'(1) << (WIDTH - 1));
    v    = (full > hi) || (full < lo);
    c    = s ? (longint'(x) >= longint'(y)) : ((longint'(x) + longint'(y)) >= (longint'(1) << WIDTH));
    r    = full[WIDTH-1:0];
`ifdef CLA_SEQ_SATURATE_EN
    if (v) r = (full > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  endtask

  // Transaction model: cycles remaining until the result appears, plus a result-pending flag
  int               m_cnt  = 0;
  bit               m_done = 1'b0;
  logic [WIDTH-1:0] m_sum  = '0;
  bit               m_cout = 1'b0;
  bit               m_ovfl = 1'b0;
  logic [WIDTH-1:0] p_sum;
  bit               p_cout, p_ovfl;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovfl = 1'b0;
    end else if (m_done) begin
      if (res_ready) m_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovfl = p_ovfl;
      end
    end else if (start_valid) begin
      ref_op(a, b, sub, p_sum, p_cout, p_ovfl);
      m_cnt = NSLICE;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk1("start_ready", start_ready, !m_done && (m_cnt == 0));
      chk1("busy", busy, m_done || (m_cnt != 0));
      chk1("res_valid", res_valid, m_done);
      chkw("sum", sum, m_sum);
      chk1("cout", cout, m_cout);
      chk1("ovfl", ovfl, m_ovfl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit s);
    int n = 0;
    while (!start_ready && n < 20) begin tick(); n++; end
    chk1("accept_ready", start_ready, 1'b1);
    a = x; b = y; sub = s; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input logic [WIDTH-1:0] es, input bit ec, input bit ev);
    int lat = 0;
    while (!res_valid && lat < 20) begin
      chk1("run_busy", busy, 1'b1);
      chk1("run_start_ready", start_ready, 1'b0);
      tick();
      lat++;
    end
    chki({nm, "_latency"}, lat, NSLICE);
    chkw({nm, "_sum"}, sum, es);
    chk1({nm, "_cout"}, cout, ec);
    chk1({nm, "_ovfl"}, ovfl, ev);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(WIDTH-1){1'b1}}};
      3:       v = {1'b1, {(WIDTH-1){1'b0}}};
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_en = 1'b1;
    chk1("reset_start_ready", start_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chkw("reset_sum", sum, '0);
    rst = 1'b0;
    tick();

    launch(16'h1234, 16'h0FED, 1'b0); collect("t1", 16'h2221, 1'b0, 1'b0); release_res();
    launch(16'h0FFF, 16'h0001, 1'b0); collect("t2a", 16'h1000, 1'b0, 1'b0); release_res();
    launch(16'h0005, 16'h0007, 1'b1); collect("t2b", 16'hFFFE, 1'b0, 1'b0); release_res();
    launch(16'h7FFF, 16'h0001, 1'b0); collect("t3a", POS_OVF, 1'b0, 1'b1); release_res();
    launch(16'h8000, 16'h0001, 1'b1); collect("t3b", NEG_OVF, 1'b1, 1'b1); release_res();

    // Back-pressure with a competing request pending
    launch(16'h1234, 16'h0FED, 1'b0); collect("t4", 16'h2221, 1'b0, 1'b0);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start_valid = 1'b1;
    repeat (3) begin
      tick();
      chkw("bp_sum", sum, 16'h2221);
      chk1("bp_start_ready", start_ready, 1'b0);
      chk1("bp_res_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk1("bp_idle", start_ready, 1'b1);
    tick();
    start_valid = 1'b0;
    collect("t4_next", 16'h0007, 1'b0, 1'b0); release_res();

    // Reset on the second RUN clock
    launch(16'hAAAA, 16'h5555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t5_res_valid", res_valid, 1'b0);
    chkw("t5_sum", sum, '0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_start_ready", start_ready, 1'b1);
    launch(16'h0001, 16'h0001, 1'b0); collect("t5_next", 16'h0002, 1'b0, 1'b0); release_res();

    // Reset beats start on the same edge
    rst = 1'b1; start_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    tick();
    rst = 1'b0; start_valid = 1'b0;
    chk1("t6_start_ready", start_ready, 1'b1);
    chk1("t6_busy", busy, 1'b0);
    tick();
    chk1("t6_not_accepted", busy, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      start_valid = $urandom_range(0, 1) == 1;
      res_ready   = $urandom_range(0, 1) == 1;
      sub         = $urandom_range(0, 1) == 1;
      a           = pick();
      b           = pick();
      tick();
    end
    rst = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    repeat (NSLICE + 3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
